rib_arbiter: RTL and testbench
==============================

Name: rib_arbiter

Overview:
- Registered round-robin arbiter that shares the single rib master port between NUM_MST requesters: core data port, JTAG debug, UART download and future DMA.
- Provides bounded-latency fairness, atomic lock sequences and a lock watchdog.
- Drives the core stall flag when the core data port is waiting.
- Sits between the requesters and the rib address decoder, in front of the slave multiplexing.

Parameters:
- NUM_MST, 4, number of requesters (2..8).
- MAX_HOLD, 8, consecutive grant cycles before forced rotation when others wait (1..255).
- LOCK_TIMEOUT, 64, maximum cycles a locked owner may hold the bus (MAX_HOLD..1023).
- CORE_MST, 0, requester index whose wait drives hold_flag_o.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req_i  in  NUM_MST  per-requester access request
- we_i  in  NUM_MST  per-requester write enable
- lock_i  in  NUM_MST  per-requester lock; suppresses MAX_HOLD rotation while owner
- addr_i  in  NUM_MST*32  packed addresses; requester i in [32*i+31:32*i]
- wdata_i  in  NUM_MST*32  packed write data
- rdata_o  out  NUM_MST*32  packed read data; only owner slice is non-zero
- gnt_o  out  NUM_MST  one-hot registered grant
- stall_o  out  NUM_MST  req_i & ~gnt_o per requester
- bus_req_o  out  1  request to rib
- bus_we_o  out  1  write enable to rib
- bus_addr_o  out  32  address to rib
- bus_wdata_o  out  32  write data to rib
- bus_rdata_i  in  32  read data from rib
- hold_flag_o  out  1  stall_o[CORE_MST]
- lock_err_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (rst low, asynchronous):
  - gnt_o=0, ptr=0, hold_cnt=0, lock_cnt=0, state IDLE, lock_err_o=0.
  - All bus outputs are 0 during reset.
- Grant is a register. A request seen in cycle n is first granted at edge n+1. The bus mux and rdata_o are combinational from gnt_o.
- bus outputs:
  - With no grant, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0.
  - With owner k: bus_req_o=req_i[k], bus_we_o=we_i[k]&req_i[k], addr and wdata are slice k.
- Search order "after x": x+1, x+2, … modulo NUM_MST, ending with x itself.
- State IDLE:
  - If any req_i, grant the first requester in search order starting at ptr (ptr itself first).
  - Then go to OWN, hold_cnt=1, lock_cnt=1.
- State OWN, owner k, evaluated each cycle in priority order:
  1. req_i[k]=0 (release):
     - ptr <= k+1 mod NUM_MST.
     - Grant the first other requester after k with zero bubble; reset counters to 1.
     - If no other requester, gnt_o=0 and go to IDLE.
  2. lock_i[k]=1 and lock_cnt==LOCK_TIMEOUT (watchdog):
     - lock_err_o pulses for 1 cycle.
     - Rotate to the next requester after k. If none, go to IDLE with gnt_o=0.
     - ptr <= k+1.
  3. lock_i[k]=0, another requester waiting, hold_cnt==MAX_HOLD:
     - Forced rotate to the next requester after k; ptr <= k+1; counters reset to 1.
  4. Otherwise keep owner k:
     - hold_cnt increments, saturating at MAX_HOLD.
     - lock_cnt increments while lock_i[k]=1, saturating at LOCK_TIMEOUT; cleared to 0 when lock_i[k]=0.
- When rotating to "next after k" and k is the only requester (possible only in rule 2), go to IDLE. k may re-win from IDLE the following cycle.
- Non-owner inputs are ignored entirely. Non-owner rdata_o slices read 0.
- Simultaneous events:
  - Release and forced rotate in the same cycle: release wins.
  - lock_i asserted by a non-owner has no effect until that requester owns the bus.
- Counter widths: 8 bits for hold_cnt, 10 bits for lock_cnt.
- Reset mid-transaction aborts immediately: grant drops and bus_req_o=0 asynchronously. After reset release, ptr restarts at 0.

Test Plan:
- Single requester: req_i=4'b0010 from cycle 0 → gnt_o=0010 at edge 1; bus_addr_o follows addr_i[63:32]; hold_flag_o=0; rotation never occurs.
- All four requesting continuously with MAX_HOLD=8 → grant sequence 0,1,2,3,0… with each owner holding exactly 8 cycles and no bubble cycles.
- Core (0) owns; requester 2 raises req; core drops req at cycle 3 → gnt_o=0100 on the next edge with no idle cycle, and ptr=1. With core re-requesting, hold_flag_o=1 until requester 2 releases or is rotated.
- Requester 1 with lock_i=1 and req held for 100 cycles, requester 3 waiting, LOCK_TIMEOUT=64:
  - No rotation at 8 cycles.
  - At lock_cnt==64, lock_err_o pulses once and gnt_o moves to 1000.
- Requester 3 writes: we_i[3]=1, addr 0x1000_0004, data 0xDEADBEEF → bus_we_o=1 with those values while owned; bus_we_o=0 in the cycle req_i[3] falls.
- Assert rst low mid-grant → gnt_o, bus_req_o and bus_we_o go to 0 without a clock edge. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing the rib master port between NUM_MST requesters.
// Registered one-hot grant with MAX_HOLD rotation, lock sequences and a lock watchdog.
//
// state | meaning
// IDLE  | no grant; next request is picked starting at ptr
// OWN   | gnt_o/own_q hold the owner; release, watchdog, forced rotation evaluated each cycle
module rib_arbiter #(
    parameter int NUM_MST      = 4,
    parameter int MAX_HOLD     = 8,
    parameter int LOCK_TIMEOUT = 64,
    parameter int CORE_MST     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_MST-1:0]      req_i,
    input  logic [NUM_MST-1:0]      we_i,
    input  logic [NUM_MST-1:0]      lock_i,
    input  logic [NUM_MST*32-1:0]   addr_i,
    input  logic [NUM_MST*32-1:0]   wdata_i,
    output logic [NUM_MST*32-1:0]   rdata_o,
    output logic [NUM_MST-1:0]      gnt_o,
    output logic [NUM_MST-1:0]      stall_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [31:0]             bus_addr_o,
    output logic [31:0]             bus_wdata_o,
    input  logic [31:0]             bus_rdata_i,
    output logic                    hold_flag_o,
    output logic                    lock_err_o
);

    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [NUM_MST-1:0] gnt_d;
    logic [IW-1:0]     own_q, own_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [7:0]        hold_q, hold_d;
    logic [9:0]        lock_q, lock_d;
    logic              err_d;

    logic [NUM_MST-1:0] others;
    logic [IW-1:0]      own_nxt;
    logic [IW:0]        idle_pick;
    logic [IW:0]        rot_pick;

    // Returns {found, index} of the first set bit of mask scanning start, start+1, ... modulo NUM_MST.
    function automatic logic [IW:0] rr_pick(input logic [NUM_MST-1:0] mask, input logic [IW-1:0] start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            idx = IW'((int'(start) + i) % NUM_MST);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        own_nxt   = IW'((int'(own_q) + 1) % NUM_MST);
        others    = req_i & ~(NUM_MST'(1) << own_q);
        idle_pick = rr_pick(req_i, ptr_q);
        rot_pick  = rr_pick(others, own_nxt);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_o;
        own_d   = own_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        lock_d  = lock_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_pick[IW]) begin
                    state_d = OWN;
                    own_d   = idle_pick[IW-1:0];
                    gnt_d   = NUM_MST'(1) << idle_pick[IW-1:0];
                    hold_d  = 8'd1;
                    lock_d  = 10'd1;
                end
            end
            OWN: begin
                if (!req_i[own_q] ||
                    (lock_i[own_q] && lock_q == 10'(LOCK_TIMEOUT)) ||
                    (!lock_i[own_q] && |others && hold_q == 8'(MAX_HOLD))) begin
                    // Release, watchdog and forced rotation all hand over to the next requester after the owner.
                    ptr_d = own_nxt;
                    err_d = req_i[own_q] && lock_i[own_q] && lock_q == 10'(LOCK_TIMEOUT);
                    if (rot_pick[IW]) begin
                        own_d  = rot_pick[IW-1:0];
                        gnt_d  = NUM_MST'(1) << rot_pick[IW-1:0];
                        hold_d = 8'd1;
                        lock_d = 10'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = 8'd0;
                        lock_d  = 10'd0;
                    end
                end else begin
                    if (hold_q != 8'(MAX_HOLD)) hold_d = hold_q + 8'd1;
                    if (!lock_i[own_q])                     lock_d = 10'd0;
                    else if (lock_q != 10'(LOCK_TIMEOUT))   lock_d = lock_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_o      <= '0;
            own_q      <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            lock_q     <= '0;
            lock_err_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_o      <= gnt_d;
            own_q      <= own_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            lock_q     <= lock_d;
            lock_err_o <= err_d;
        end
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        rdata_o     = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (gnt_o[i]) begin
                bus_req_o          = req_i[i];
                bus_we_o           = we_i[i] & req_i[i];
                bus_addr_o         = addr_i[32*i +: 32];
                bus_wdata_o        = wdata_i[32*i +: 32];
                rdata_o[32*i +: 32] = bus_rdata_i;
            end
        end
    end

    assign stall_o     = req_i & ~gnt_o;
    assign hold_flag_o = stall_o[CORE_MST];

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter with hand-computed expectations (NUM_MST=4, MAX_HOLD=8, LOCK_TIMEOUT=64).
module tb_rib_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_i, we_i, lock_i;
    logic [127:0] addr_i, wdata_i, rdata_o;
    logic [3:0]   gnt_o, stall_o;
    logic         bus_req_o, bus_we_o, hold_flag_o, lock_err_o;
    logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i;

    int checks   = 0;
    int failures = 0;

    rib_arbiter #(.NUM_MST(4), .MAX_HOLD(8), .LOCK_TIMEOUT(64), .CORE_MST(0)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .gnt_o(gnt_o), .stall_o(stall_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .hold_flag_o(hold_flag_o), .lock_err_o(lock_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b0;
        req_i       = '0;
        we_i        = '0;
        lock_i      = '0;
        addr_i      = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0000_00A0};
        wdata_i     = {32'h3333_D000, 32'h2222_D000, 32'h1111_D000, 32'h0000_D000};
        bus_rdata_i = 32'hCAFE_0001;
        #2;
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_lock_err", lock_err_o, 1'b0);
        tick(2);
        rst = 1'b1;

        // single requester 1
        req_i = 4'b0010;
        tick(1);
        chk("single_gnt", gnt_o, 4'b0010);
        chk("single_addr", bus_addr_o, 32'h1111_0000);
        chk("single_req", bus_req_o, 1'b1);
        chk("single_hold_flag", hold_flag_o, 1'b0);
        chk("single_rdata", rdata_o, {32'h0, 32'h0, 32'hCAFE_0001, 32'h0});
        tick(20);
        chk("single_no_rotate", gnt_o, 4'b0010);
        req_i = 4'b0000;
        tick(1);
        chk("single_release_idle", gnt_o, 4'b0000);

        // all four requesting; ptr is 2 after requester 1 released
        req_i = 4'b1111;
        tick(1);
        chk("rr_first", gnt_o, 4'b0100);
        tick(7);
        chk("rr_hold8", gnt_o, 4'b0100);
        tick(1);
        chk("rr_to3", gnt_o, 4'b1000);
        tick(8);
        chk("rr_to0", gnt_o, 4'b0001);
        chk("rr_stall0", stall_o, 4'b1110);
        chk("rr_hold_flag0", hold_flag_o, 1'b0);
        tick(8);
        chk("rr_to1", gnt_o, 4'b0010);
        chk("rr_hold_flag1", hold_flag_o, 1'b1);
        tick(8);
        chk("rr_to2", gnt_o, 4'b0100);
        req_i = 4'b0000;
        tick(1);
        chk("rr_release_idle", gnt_o, 4'b0000);

        // core owns, requester 2 waits, core releases; ptr is 3 here
        req_i = 4'b0001;
        tick(1);
        chk("core_gnt", gnt_o, 4'b0001);
        req_i = 4'b0101;
        tick(2);
        chk("core_keep", gnt_o, 4'b0001);
        req_i = 4'b0100;
        tick(1);
        chk("core_release_handover", gnt_o, 4'b0100);
        req_i = 4'b0101;
        #1;
        chk("core_hold_flag_on", hold_flag_o, 1'b1);
        tick(7);
        chk("core_wait_still", gnt_o, 4'b0100);
        chk("core_hold_flag_still", hold_flag_o, 1'b1);
        tick(1);
        chk("core_rotated_in", gnt_o, 4'b0001);
        chk("core_hold_flag_off", hold_flag_o, 1'b0);
        req_i = 4'b0000;
        tick(1);
        chk("core_release_idle", gnt_o, 4'b0000);

        // ptr is now 1: requester 1 wins over 0; locked owner, watchdog after 64 cycles
        req_i  = 4'b1011;
        lock_i = 4'b0010;
        tick(1);
        chk("lock_ptr_gnt", gnt_o, 4'b0010);
        tick(8);
        chk("lock_no_rotate8", gnt_o, 4'b0010);
        chk("lock_hold_flag", hold_flag_o, 1'b1);
        tick(55);
        chk("lock_before_wd", gnt_o, 4'b0010);
        chk("lock_err_quiet", lock_err_o, 1'b0);
        tick(1);
        chk("lock_wd_gnt", gnt_o, 4'b1000);
        chk("lock_err_pulse", lock_err_o, 1'b1);
        tick(1);
        chk("lock_err_one_cycle", lock_err_o, 1'b0);

        // requester 3 write while owner
        req_i   = 4'b1000;
        lock_i  = 4'b0000;
        we_i    = 4'b1000;
        addr_i[127:96]  = 32'h1000_0004;
        wdata_i[127:96] = 32'hDEAD_BEEF;
        bus_rdata_i     = 32'h1234_5678;
        #1;
        chk("wr_gnt", gnt_o, 4'b1000);
        chk("wr_we", bus_we_o, 1'b1);
        chk("wr_addr", bus_addr_o, 32'h1000_0004);
        chk("wr_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        chk("wr_rdata", rdata_o, {32'h1234_5678, 96'h0});
        req_i = 4'b0000;
        #1;
        chk("wr_we_drop", bus_we_o, 1'b0);
        chk("wr_req_drop", bus_req_o, 1'b0);
        tick(1);
        chk("wr_release_idle", gnt_o, 4'b0000);

        // asynchronous reset mid-grant
        req_i = 4'b0001;
        we_i  = 4'b0001;
        tick(1);
        chk("arst_pre_gnt", gnt_o, 4'b0001);
        chk("arst_pre_we", bus_we_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_gnt", gnt_o, 4'b0000);
        chk("arst_bus_req", bus_req_o, 1'b0);
        chk("arst_bus_we", bus_we_o, 1'b0);
        req_i = 4'b0110;
        we_i  = 4'b0000;
        #1;
        rst = 1'b1;
        tick(1);
        chk("arst_first_gnt", gnt_o, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
